// File: rtl/shot_judge_if.sv
// Signal bundle between the shot judge and the game logic around it:
// crosshair, duck, trigger and frame strobe going in, and judgement and score coming out.
interface shot_judge_if;
    logic        frame_clk;
    logic        trigger;
    logic [9:0]  cursor_x;
    logic [9:0]  cursor_y;
    logic [18:0] duck_center;
    logic        duck_active;
    logic        round_start;
    logic        duck_dead;
    logic        duck_hit;
    logic        duck_escaped;
    logic [1:0]  shots_left;
    logic [15:0] score;

    modport master (
        output frame_clk, trigger, cursor_x, cursor_y, duck_center, duck_active, round_start,
        input  duck_dead, duck_hit, duck_escaped, shots_left, score
    );

    modport slave (
        input  frame_clk, trigger, cursor_x, cursor_y, duck_center, duck_active, round_start,
        output duck_dead, duck_hit, duck_escaped, shots_left, score
    );
endinterface

// File: rtl/shot_judge.sv
// Judges gun shots against the duck position: square hit window, per-duck shot budget,
// frame-timed hit/miss hold periods and a saturating score.
module shot_judge #(
    parameter logic [9:0]  HIT_RADIUS     = 10'd12,
    parameter logic [5:0]  HOLD_FRAMES    = 6'd30,
    parameter logic [1:0]  SHOTS_PER_DUCK = 2'd3,
    parameter logic [15:0] POINTS         = 16'd500
) (
    input  logic         Clk,
    input  logic         Reset,
    shot_judge_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        AIM       = 3'd1,
        FIRE      = 3'd2,
        HIT_HOLD  = 3'd3,
        MISS_HOLD = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [5:0]  hold_cnt_reg, hold_cnt_next;
    logic [1:0]  trig_sync_reg;
    logic        trig_prev_reg;
    logic        frame_prev_reg;
    logic [1:0]  shots_reg;
    logic [15:0] score_reg;
    logic        dead_reg, hit_reg, esc_reg;
    logic [9:0]  cx_reg, cy_reg;
    logic [18:0] dc_reg;

    logic        fire_evt, frame_rise, hold_done, hit_w;
    logic        load_shots, dec_shot, add_points, capture, hit_next, esc_next;
    logic [10:0] dx, dy, duck_x_ext, duck_y_ext, cur_x_ext, cur_y_ext;
    logic [16:0] score_sum;

    // The edge detector looks at the synchronized copy only, so a trigger held through
    // reset cannot produce a fire event on the first cycle out of reset.
    assign fire_evt   = trig_sync_reg[1] & ~trig_prev_reg;
    assign frame_rise = bus.frame_clk & ~frame_prev_reg;
    assign hold_done  = frame_rise && (hold_cnt_reg == HOLD_FRAMES - 6'd1);

    assign cur_x_ext  = {1'b0, cx_reg};
    assign cur_y_ext  = {1'b0, cy_reg};
    assign duck_x_ext = {1'b0, dc_reg[18:9]};
    assign duck_y_ext = {2'b00, dc_reg[8:0]};
    assign dx = (cur_x_ext >= duck_x_ext) ? cur_x_ext - duck_x_ext : duck_x_ext - cur_x_ext;
    assign dy = (cur_y_ext >= duck_y_ext) ? cur_y_ext - duck_y_ext : duck_y_ext - cur_y_ext;
    assign hit_w = (dx <= {1'b0, HIT_RADIUS}) && (dy <= {1'b0, HIT_RADIUS});

    assign score_sum = {1'b0, score_reg} + {1'b0, POINTS};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= 6'd0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        load_shots    = 1'b0;
        dec_shot      = 1'b0;
        add_points    = 1'b0;
        capture       = 1'b0;
        hit_next      = 1'b0;
        esc_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.round_start) begin
                    state_next    = AIM;
                    load_shots    = 1'b1;
                    hold_cnt_next = 6'd0;
                end
            end
            AIM: begin
                if (!bus.duck_active) begin
                    state_next = IDLE;
                    esc_next   = 1'b1;
                end else if (fire_evt) begin
                    state_next = FIRE;
                    capture    = 1'b1;
                end
            end
            FIRE: begin
                if (hit_w) begin
                    state_next = HIT_HOLD;
                    add_points = 1'b1;
                    hit_next   = 1'b1;
                end else begin
                    state_next = MISS_HOLD;
                    dec_shot   = 1'b1;
                end
            end
            HIT_HOLD: begin
                if (hold_done) begin
                    state_next    = IDLE;
                    hold_cnt_next = 6'd0;
                end else if (frame_rise) begin
                    hold_cnt_next = hold_cnt_reg + 6'd1;
                end
            end
            MISS_HOLD: begin
                if (hold_done) begin
                    hold_cnt_next = 6'd0;
                    if (shots_reg != 2'd0) begin
                        state_next = AIM;
                    end else begin
                        state_next = IDLE;
                        esc_next   = 1'b1;
                    end
                end else if (frame_rise) begin
                    hold_cnt_next = hold_cnt_reg + 6'd1;
                end
            end
            default: begin
                state_next    = IDLE;
                hold_cnt_next = 6'd0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            trig_sync_reg  <= 2'b00;
            trig_prev_reg  <= 1'b0;
            frame_prev_reg <= 1'b0;
            shots_reg      <= 2'd0;
            score_reg      <= 16'd0;
            dead_reg       <= 1'b0;
            hit_reg        <= 1'b0;
            esc_reg        <= 1'b0;
            cx_reg         <= 10'd0;
            cy_reg         <= 10'd0;
            dc_reg         <= 19'd0;
        end else begin
            trig_sync_reg  <= {trig_sync_reg[0], bus.trigger};
            trig_prev_reg  <= trig_sync_reg[1];
            frame_prev_reg <= bus.frame_clk;
            dead_reg       <= (state_next == HIT_HOLD);
            hit_reg        <= hit_next;
            esc_reg        <= esc_next;
            if (load_shots) begin
                shots_reg <= SHOTS_PER_DUCK;
            end else if (dec_shot && shots_reg != 2'd0) begin
                shots_reg <= shots_reg - 2'd1;
            end
            if (add_points) begin
                score_reg <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            end
            if (capture) begin
                cx_reg <= bus.cursor_x;
                cy_reg <= bus.cursor_y;
                dc_reg <= bus.duck_center;
            end
        end
    end

    assign bus.duck_dead    = dead_reg;
    assign bus.duck_hit     = hit_reg;
    assign bus.duck_escaped = esc_reg;
    assign bus.shots_left   = shots_reg;
    assign bus.score        = score_reg;

endmodule

// File: tb/tb_shot_judge.sv
// Bench for shot_judge: hit/escape events are predicted into a scoreboard queue when
// stimulus is driven and matched against the pulses the judge produces.
module tb_shot_judge;

    localparam int HOLD = 30;

    logic Clk = 1'b0;
    logic Reset;
    shot_judge_if bus();

    shot_judge dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #10 Clk = ~Clk;

    typedef struct {
        bit          is_hit;
        logic [15:0] score;
        logic [1:0]  shots;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   dead_frames = 0;
    bit   frame_prev_tb = 1'b0;
    bit   dead_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame strobe: one cycle high out of every four, changed on the falling edge.
    initial begin
        bus.frame_clk = 1'b0;
        forever begin
            repeat (3) @(negedge Clk);
            bus.frame_clk = 1'b1;
            @(negedge Clk);
            bus.frame_clk = 1'b0;
        end
    end

    // Output monitor: pops the scoreboard on each event pulse and counts hold frames.
    always @(negedge Clk) begin
        exp_t e;
        if (bus.duck_dead && !dead_prev) dead_frames = 0;
        if (bus.duck_dead && bus.frame_clk && !frame_prev_tb) dead_frames++;
        dead_prev     = bus.duck_dead;
        frame_prev_tb = bus.frame_clk;
        if (bus.duck_hit || bus.duck_escaped) begin
            check("hit_esc_exclusive", {31'd0, bus.duck_hit & bus.duck_escaped}, 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_event", {30'd0, bus.duck_hit, bus.duck_escaped}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check(e.is_hit ? "hit_pulse" : "escape_pulse",
                      {30'd0, bus.duck_hit, bus.duck_escaped}, e.is_hit ? 32'd2 : 32'd1);
                check("event_score", {16'd0, bus.score}, {16'd0, e.score});
                check("event_shots", {30'd0, bus.shots_left}, {30'd0, e.shots});
                $display("event %s score=%0d shots=%0d", e.is_hit ? "hit" : "escape",
                         bus.score, bus.shots_left);
            end
        end
    end

    task automatic push_exp(input bit is_hit, input logic [15:0] score, input logic [1:0] shots);
        exp_t e;
        e.is_hit = is_hit;
        e.score  = score;
        e.shots  = shots;
        sb_q.push_back(e);
    endtask

    task automatic start_round();
        @(negedge Clk);
        bus.round_start = 1'b1;
        @(negedge Clk);
        bus.round_start = 1'b0;
        @(negedge Clk);
    endtask

    task automatic pull_trigger();
        @(negedge Clk);
        bus.trigger = 1'b1;
        repeat (3) @(negedge Clk);
        bus.trigger = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic aim(input logic [9:0] dxp, input logic [8:0] dyp,
                       input logic [9:0] cx, input logic [9:0] cy);
        bus.duck_center = {dxp, dyp};
        bus.cursor_x    = cx;
        bus.cursor_y    = cy;
    endtask

    // Waits out a hit hold, optionally pulling the trigger in the middle of it.
    task automatic wait_hit_hold(input bit shoot_during);
        int n;
        n = 0;
        while (!bus.duck_dead && n < 40) begin
            @(negedge Clk);
            n++;
        end
        check("dead_rise", {31'd0, bus.duck_dead}, 32'd1);
        if (shoot_during) pull_trigger();
        n = 0;
        while (bus.duck_dead && n < 400) begin
            @(negedge Clk);
            n++;
        end
        check("dead_fall", {31'd0, bus.duck_dead}, 32'd0);
        check("dead_frames", dead_frames, HOLD);
        repeat (2) @(negedge Clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_score"}, {16'd0, bus.score}, 32'd0);
        check({tag, "_shots"}, {30'd0, bus.shots_left}, 32'd0);
        check({tag, "_flags"}, {29'd0, bus.duck_dead, bus.duck_hit, bus.duck_escaped}, 32'd0);
    endtask

    logic [15:0] exp_score;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset           = 1'b1;
        bus.trigger     = 1'b1;
        bus.round_start = 1'b0;
        bus.duck_active = 1'b1;
        aim(10'd320, 9'd240, 10'd325, 10'd235);
        repeat (4) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check_reset_outputs("reset");
        repeat (4) @(negedge Clk);
        bus.trigger = 1'b0;
        repeat (2) @(negedge Clk);
        check_reset_outputs("idle_after_reset");

        // Plain hit near the centre.
        start_round();
        check("round_shots", {30'd0, bus.shots_left}, 32'd3);
        push_exp(1'b1, 16'd500, 2'd3);
        pull_trigger();
        wait_hit_hold(1'b0);
        check("hit_score", {16'd0, bus.score}, 32'd500);

        // Three misses, then the duck escapes.
        start_round();
        aim(10'd320, 9'd240, 10'd0, 10'd0);
        check("miss_start_shots", {30'd0, bus.shots_left}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) push_exp(1'b0, 16'd500, 2'd0);
            pull_trigger();
            repeat (160) @(negedge Clk);
            check("miss_shots", {30'd0, bus.shots_left}, 2 - i);
            $display("miss %0d shots_left=%0d", i, bus.shots_left);
        end
        check("miss_score", {16'd0, bus.score}, 32'd500);

        // Window edges: +12 hits, +13 misses, and a left edge clamped at pixel 0.
        start_round();
        aim(10'd100, 9'd100, 10'd112, 10'd100);
        push_exp(1'b1, 16'd1000, 2'd3);
        pull_trigger();
        wait_hit_hold(1'b0);
        start_round();
        aim(10'd100, 9'd100, 10'd113, 10'd100);
        pull_trigger();
        repeat (160) @(negedge Clk);
        check("edge13_shots", {30'd0, bus.shots_left}, 32'd2);
        check("edge13_score", {16'd0, bus.score}, 32'd1000);
        aim(10'd5, 9'd100, 10'd0, 10'd100);
        push_exp(1'b1, 16'd1500, 2'd2);
        pull_trigger();
        wait_hit_hold(1'b0);

        // Duck leaves in the same cycle the fire event appears.
        start_round();
        aim(10'd320, 9'd240, 10'd320, 10'd240);
        push_exp(1'b0, 16'd1500, 2'd3);
        @(negedge Clk);
        bus.trigger = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        bus.duck_active = 1'b0;
        @(negedge Clk);
        bus.trigger = 1'b0;
        repeat (4) @(negedge Clk);
        check("prio_shots", {30'd0, bus.shots_left}, 32'd3);
        check("prio_score", {16'd0, bus.score}, 32'd1500);
        bus.duck_active = 1'b1;

        // A second trigger pull during the hit hold must not count.
        start_round();
        push_exp(1'b1, 16'd2000, 2'd3);
        pull_trigger();
        wait_hit_hold(1'b1);
        check("discard_score", {16'd0, bus.score}, 32'd2000);

        // Drive the score up to the saturation limit.
        exp_score = 16'd2000;
        for (int i = 0; i < 128; i++) begin
            exp_score = (32'(exp_score) + 32'd500 > 32'hFFFF) ? 16'hFFFF : exp_score + 16'd500;
            start_round();
            push_exp(1'b1, exp_score, 2'd3);
            pull_trigger();
            wait_hit_hold(1'b0);
        end
        check("sat_score", {16'd0, bus.score}, 32'h0000FFFF);

        // Reset in the middle of a miss hold.
        start_round();
        aim(10'd320, 9'd240, 10'd0, 10'd0);
        pull_trigger();
        repeat (10) @(negedge Clk);
        check("pre_reset_shots", {30'd0, bus.shots_left}, 32'd2);
        Reset = 1'b1;
        @(negedge Clk);
        check_reset_outputs("mid_hold_reset");
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shot_judge.md
SHOT_JUDGE -- requirements
Module: shot_judge

Interface
REQ-001 Parameter HIT_RADIUS, default 10'd12: half-width of the square hit window around the duck center, in pixels.
REQ-002 Parameter HOLD_FRAMES, default 6'd30: number of frame_clk rising edges spent in each hold state.
REQ-003 Parameter SHOTS_PER_DUCK, default 2'd3: shots loaded at round start.
REQ-004 Parameter POINTS, default 16'd500: score added per hit.
REQ-005 Clk  input  1  50 MHz system clock; single clock domain.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 frame_clk  input  1  frame strobe (~60 Hz), synchronous to Clk.
REQ-008 trigger  input  1  raw gun/mouse button, asynchronous, active-high.
REQ-009 cursor_x  input  10  crosshair X pixel.
REQ-010 cursor_y  input  10  crosshair Y pixel.
REQ-011 duck_center  input  19  duck position: [18:9] = X, [8:0] = Y.
REQ-012 duck_active  input  1  high while the duck is on screen and shootable.
REQ-013 round_start  input  1  one-cycle pulse that arms a new duck.
REQ-014 duck_dead  output  1  level, high throughout HIT_HOLD; drives the duck fall behaviour.
REQ-015 duck_hit  output  1  one-cycle pulse on entry to HIT_HOLD.
REQ-016 duck_escaped  output  1  one-cycle pulse when the duck is lost.
REQ-017 shots_left  output  2  remaining shots.
REQ-018 score  output  16  accumulated score, unsigned.

Function
REQ-019 trigger shall pass through a 2-flop synchronizer, then a rising-edge detector; a fire event is one Clk cycle wide.
REQ-020 States: IDLE, AIM, FIRE, HIT_HOLD, MISS_HOLD.
REQ-021 IDLE: on round_start go to AIM, shots_left <= SHOTS_PER_DUCK, hold counter cleared; all other inputs are ignored.
REQ-022 AIM: if duck_active is low, go to IDLE, pulse duck_escaped; else on fire event go to FIRE; duck_active low has priority over a same-cycle fire event.
REQ-023 FIRE lasts exactly one cycle: it registers cursor_x, cursor_y and duck_center, and computes hit = |cursor_x - X| <= HIT_RADIUS AND |cursor_y - Y| <= HIT_RADIUS.
REQ-024 Differences shall use 11-bit unsigned absolute value; Y shall be zero-extended to 10 bits; no wrap-around.
REQ-025 FIRE to HIT_HOLD on hit: duck_hit pulses in the first HIT_HOLD cycle; score <= score + POINTS, saturating at 16'hFFFF.
REQ-026 FIRE to MISS_HOLD on miss: shots_left decrements by 1 and never goes below 0.
REQ-027 Each hold state counts frame_clk rising edges (edge detected in Clk domain); after HOLD_FRAMES edges it exits and clears the counter.
REQ-028 HIT_HOLD exits to IDLE.
REQ-029 MISS_HOLD exits to AIM if shots_left > 0; otherwise to IDLE with a duck_escaped pulse.
REQ-030 Fire events outside AIM are discarded, not queued; round_start outside IDLE is ignored.
REQ-031 duck_dead = (state == HIT_HOLD), registered.
REQ-032 duck_escaped and duck_hit shall never be high in the same cycle.

Reset
REQ-033 Reset overrides all else, including mid-hold: state IDLE, score 0, shots_left 0, duck_dead 0, duck_hit 0, duck_escaped 0, hold counter 0, synchronizer and edge flops 0.
REQ-034 The first cycle after Reset deasserts shall not produce a fire event, even if trigger is held high.

Verification
REQ-035 Hit: round_start; duck_center = {10'd320, 9'd240}; cursor (325, 235); trigger pulse -> duck_hit once; score = 500; duck_dead high for 30 frame_clk edges; then IDLE.
REQ-036 Three misses: cursor (0, 0); three triggers, each spaced after the hold ends -> shots_left 3, 2, 1, 0; one duck_escaped after the final MISS_HOLD; score unchanged.
REQ-037 Boundary: cursor_x exactly X + 12 gives a hit; X + 13 gives a miss; X = 5 with cursor_x = 0 gives a hit (no underflow).
REQ-038 Priority and discard: duck_active falls in the same cycle as a fire event in AIM -> duck_escaped, IDLE, shots_left unchanged; trigger during HIT_HOLD is ignored.
REQ-039 Saturation and reset: preload score to 16'hFF00, then hit -> 16'hFFFF; assert Reset in MISS_HOLD -> all outputs at reset values on the next cycle.
